md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit instantiated in the execute stage, beside the ALU.
- It consumes the forwarded rs/rt operands that the execute stage already selects for the ALU.
- It owns the HI/LO architectural registers and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It exports a busy flag that the hazard controller combines with start to stall D-stage multiply/divide and MFHI/MFLO instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU. Legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: reset=0 sampled on a clk rising edge clears the unit.
- start  input  1  one-cycle request, valid with MDOp/A/B.
- MDOp  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=reserved (treated as NONE).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  high while a multiply/divide is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset=0 at edge):
  - HI=0, LO=0, busy=0, counter=0, pending results=0, state=IDLE.
  - Reset overrides start and aborts any in-flight operation; no HI/LO commit occurs.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; internal 4-bit down-counter and 64-bit pending {hi,lo}.
- IDLE, start=1, MDOp in 1..4 at edge T:
  - Compute the result combinationally from A/B and latch it into pending.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state goes to RUN.
  - busy is high in cycles T+1 .. T+N (N = latency).
- RUN: the counter decrements each edge. On the edge where counter==1:
  - HI/LO take pending; state goes to IDLE; busy drops.
  - New HI/LO are visible in the same cycle busy reads 0.
- Arithmetic:
  - MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV/DIVU with B==0: the operation still occupies busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO:
  - In IDLE with start=1: HI (or LO) takes A at that edge; no busy cycle; the value is readable the next cycle.
- Start while busy:
  - Any start with busy=1, including MTHI/MTLO, is ignored; in-flight state is untouched.
  - The hazard controller guarantees this cannot happen in legal operation.
  - The bench checks that the unit stays robust if it does.
- NONE/reserved MDOp with start=1: no effect.
- start=0: MDOp/A/B are don't-care.
- No combinational path from inputs to busy, HI or LO; all outputs are registered.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=4 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF4.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Repeat with MULT -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then DIVU A=5, B=0 -> busy 10 cycles, HI stays 0x12345678, LO stays 0.
- Start MULT 3*3, then on busy cycle 2 assert start with MTLO A=0xDEAD -> ignored; completion gives HI=0, LO=9.
- Start DIV 100/7, drive reset=0 on busy cycle 4 -> next cycle busy=0, HI=0, LO=0; no later commit. A subsequent MULT 2*3 yields LO=6.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the execute stage.
//
// Owns the architectural HI/LO registers. A MULT/MULTU/DIV/DIVU request is
// evaluated combinationally when it is accepted. The result waits in a
// pending register while a down-counter models the unit latency. HI/LO are
// written when the counter expires. MTHI/MTLO write HI/LO directly when the
// unit is idle. Every output is registered.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low clear
//   start  - one-cycle request qualifier for MDOp/A/B
//   MDOp   - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A, B   - forwarded rs / rt operands
//   busy   - high while a multiply/divide is in flight
//   HI, LO - architectural HI / LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_commit;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Products: the low 64 bits of a product of sign-extended operands are the
  // signed 64-bit product, so no signed arithmetic operators are needed.
  logic [63:0] w_prod_u;
  logic [63:0] w_prod_s;

  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Division: a single unsigned divider works on operand magnitudes. For
  // DIV, signs are restored afterwards. The quotient is negative when the
  // operand signs differ, and the remainder takes the sign of the dividend.
  // Because the magnitude of 0x80000000 is itself as an unsigned value,
  // 0x80000000 / -1 gives 0x80000000 with no special case. A zero divisor
  // is replaced by 1 only to keep the divider defined. That result is
  // never committed.
  logic        w_div_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_div_lo;
  logic [31:0] w_div_hi;
  logic        w_b_zero;

  assign w_div_signed = (MDOp == OP_DIV);
  assign w_b_zero     = (B == 32'd0);
  assign w_a_mag      = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_b_mag      = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
  assign w_b_safe     = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_div_lo     = (w_div_signed && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_div_hi     = (w_div_signed && A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_pend   <= 64'd0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (MDOp)
              OP_MULT: begin
                r_pend   <= w_prod_s;
                r_commit <= 1'b1;
                r_cnt    <= LP_MULT_CNT;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              OP_MULTU: begin
                r_pend   <= w_prod_u;
                r_commit <= 1'b1;
                r_cnt    <= LP_MULT_CNT;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_pend   <= {w_div_hi, w_div_lo};
                r_commit <= !w_b_zero;    // divide by zero keeps HI/LO
                r_cnt    <= LP_DIV_CNT;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;                  // NONE / reserved
            endcase
          end
        end
        S_RUN: begin
          // Requests arriving while busy are dropped here on purpose.
          if (r_cnt == 4'd1) begin
            if (r_commit) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit. The driver issues requests and pushes the expected
// completion (HI, LO, busy length) into a scoreboard queue. The expected
// values come from a plain-arithmetic reference model. A monitor pops an
// entry and compares it each time busy falls.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= (reset === 1'b0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural behaviour computed with wide integers.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    e.hi = m_hi;
    e.lo = m_lo;
    e.op = op;
    e.len = (op == 3'd1 || op == 3'd2) ? MC : DC;
    case (op)
      3'd1: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = 64'(sa * sbv);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd3: if (b != 0) begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        q = sa / sbv;
        r = sa % sbv;
        e.lo = 32'(q);
        e.hi = 32'(r);
      end
      3'd4: if (b != 0) begin
        e.lo = a / b;
        e.hi = a % b;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: a busy falling edge marks a completion (or a reset abort).
  initial begin : monitor
    logic prev_busy;
    int   run_len;
    exp_t e;
    prev_busy = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        sb.delete();
        run_len = 0;
      end else if (busy === 1'b1) begin
        run_len++;
      end else begin
        if (prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion actual=%h required=none", {HI, LO});
          end else begin
            e = sb.pop_front();
            chk("busy_len", 32'(run_len), 32'(e.len));
            chk("hi", HI, e.hi);
            chk("lo", LO, e.lo);
            $display("txn op=%0d len=%0d HI=%h LO=%h", e.op, run_len, HI, LO);
          end
        end
        run_len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%b required=0", busy);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    MDOp = op;
    A = a;
    B = b;
    e = model(op, a, b);
    if (op >= 3'd1 && op <= 3'd4) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    MDOp = 3'($urandom);
    A = $urandom;
    B = $urandom;
    if (op >= 3'd1 && op <= 3'd4) begin
      chk("busy_rise", {31'd0, busy}, 32'd1);
      wait_idle();
      m_hi = e.hi;
      m_lo = e.lo;
    end else begin
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      chk("hi_direct", HI, m_hi);
      chk("lo_direct", LO, m_lo);
      chk("busy_direct", {31'd0, busy}, 32'd0);
      $display("txn op=%0d a=%h HI=%h LO=%h", op, a, HI, LO);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b0;
    start = 1'b0;
    MDOp = 3'd0;
    A = 32'd0;
    B = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFD, 32'd4);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    issue(3'd4, 32'd7, 32'd2);
    issue(3'd6, 32'd0, 32'd0);
    issue(3'd5, 32'h1234_5678, 32'd0);
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd0, 32'hAAAA_AAAA, 32'd1);
    issue(3'd7, 32'h5555_5555, 32'd1);

    // Requests while busy must be ignored.
    @(negedge clk);
    start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd3;
    sb.push_back(model(3'd1, 32'd3, 32'd3));
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; MDOp = 3'd6; A = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    m_hi = 32'd0;
    m_lo = 32'd9;
    chk("ignored_lo", LO, 32'd9);

    // Reset during a divide aborts it without a commit.
    @(negedge clk);
    start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
    sb.push_back(model(3'd3, 32'd100, 32'd7));
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (15) @(negedge clk);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);
    issue(3'd1, 32'd2, 32'd3);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
